// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: direction and boundary-mode encodings.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/sync_updown_counter_if.sv
// Control and status bundle for sync_updown_counter; master drives controls, slave is the counter.
interface sync_updown_counter_if
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] mod_max;
  logic             sat;
  logic [WIDTH-1:0] q;
  logic             tc;

  modport master (
    output en, up, load, load_val, mod_max, sat,
    input  q, tc
  );

  modport slave (
    input  en, up, load, load_val, mod_max, sat,
    output q, tc
  );

endinterface

// File: rtl/dff_vec.sv
// WIDTH-bit register with asynchronous active-low reset to a fixed value.
module dff_vec #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/sync_updown_counter.sv
// Up/down counter with load, programmable modulus and wrap/saturate; registered terminal count.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned RESET_VALUE = 0
) (
  input logic                 clk,
  input logic                 rst,
  sync_updown_counter_if.slave bus
);

  logic [WIDTH-1:0] q_d, q_q;
  logic             tc_d, tc_q;

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (bus.load) begin
      q_d = (bus.load_val > bus.mod_max) ? bus.mod_max : bus.load_val;
    end else if (bus.en) begin
      if (bus.up == DIR_UP) begin
        if (q_q < bus.mod_max) begin
          q_d = q_q + WIDTH'(1);
        end else begin
          q_d  = (bus.sat == MODE_SAT) ? bus.mod_max : '0;
          tc_d = 1'b1;
        end
      end else begin
        if (q_q == '0) begin
          q_d  = (bus.sat == MODE_SAT) ? '0 : bus.mod_max;
          tc_d = 1'b1;
        end else if (q_q > bus.mod_max) begin
          // Modulus was lowered under us: snap back into range without a boundary pulse.
          q_d = bus.mod_max;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  dff_vec #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(WIDTH'(RESET_VALUE))
  ) u_q_reg (
    .clk(clk),
    .rst(rst),
    .d  (q_d),
    .q  (q_q)
  );

  dff_vec #(
    .WIDTH      (1),
    .RESET_VALUE(1'b0)
  ) u_tc_reg (
    .clk(clk),
    .rst(rst),
    .d  (tc_d),
    .q  (tc_q)
  );

  assign bus.q  = q_q;
  assign bus.tc = tc_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed plus randomized bench for sync_updown_counter against an integer reference model.
module tb_sync_updown_counter;

  localparam int unsigned W  = 4;
  localparam int unsigned RV = 5;

  logic clk;
  logic rst;

  sync_updown_counter_if #(.WIDTH(W)) bus ();

  sync_updown_counter #(
    .WIDTH      (W),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int mq = RV;
  int mt = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: apply the counting rules to plain integers.
  task automatic model_edge();
    int mm, lv;
    mm = int'(bus.mod_max);
    lv = int'(bus.load_val);
    if (!rst) begin
      mq = RV;
      mt = 0;
    end else if (bus.load) begin
      mq = (lv < mm) ? lv : mm;
      mt = 0;
    end else if (!bus.en) begin
      mt = 0;
    end else if (bus.up) begin
      if (mq < mm) begin
        mq = mq + 1;
        mt = 0;
      end else begin
        mq = bus.sat ? mm : 0;
        mt = 1;
      end
    end else begin
      if (mq == 0) begin
        mq = bus.sat ? 0 : mm;
        mt = 1;
      end else if (mq > mm) begin
        mq = mm;
        mt = 0;
      end else begin
        mq = mq - 1;
        mt = 0;
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".q"}, int'(bus.q), mq);
    check({tag, ".tc"}, int'(bus.tc), mt);
  endtask

  task automatic step(input string tag, input int eq, input int etc);
    cycle(tag);
    check({tag, ".q_exp"}, int'(bus.q), eq);
    check({tag, ".tc_exp"}, int'(bus.tc), etc);
  endtask

  task automatic do_load(input int val, input int mm);
    bus.load     = 1'b1;
    bus.load_val = W'(val);
    bus.mod_max  = W'(mm);
    cycle("load");
    bus.load     = 1'b0;
  endtask

  int tc_count;

  initial begin
    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.up       = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.mod_max  = '0;
    bus.sat      = 1'b0;

    #12;
    check("reset.q", int'(bus.q), RV);
    check("reset.tc", int'(bus.tc), 0);

    // Release between edges; first edge is a normal step.
    rst         = 1'b1;
    bus.en      = 1'b1;
    bus.up      = 1'b1;
    bus.mod_max = 4'd15;
    step("first_step", 6, 0);

    // Asynchronous reset pulse with no clock edge.
    rst = 1'b0;
    #1;
    check("async_rst.q", int'(bus.q), RV);
    check("async_rst.tc", int'(bus.tc), 0);
    mq = RV;
    mt = 0;
    #1;
    rst = 1'b1;

    // Down wrap.
    do_load(1, 15);
    bus.en = 1'b1;
    bus.up = 1'b0;
    bus.sat = 1'b0;
    step("dwrap0", 0, 0);
    step("dwrap1", 15, 1);
    step("dwrap2", 14, 0);

    // Up modulus 9.
    do_load(8, 9);
    bus.up = 1'b1;
    step("umod0", 9, 0);
    step("umod1", 0, 1);
    step("umod2", 1, 0);

    // Pulse train period is 10 enabled cycles.
    do_load(0, 9);
    tc_count = 0;
    for (int i = 0; i < 30; i++) begin
      cycle("period");
      if (bus.tc) tc_count++;
    end
    check("period.count", tc_count, 3);

    // Saturate.
    do_load(8, 9);
    bus.sat = 1'b1;
    bus.up  = 1'b1;
    step("sat0", 9, 0);
    step("sat1", 9, 1);
    step("sat2", 9, 1);
    bus.up = 1'b0;
    step("sat_down", 8, 0);

    // Load beats enable and is clamped; then lowered modulus pulls q down.
    bus.sat      = 1'b0;
    bus.en       = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 4'd12;
    bus.mod_max  = 4'd9;
    step("load_pri", 9, 0);
    bus.load     = 1'b0;
    bus.mod_max  = 4'd3;
    bus.up       = 1'b0;
    step("lower_mod", 3, 0);

    // mod_max = 0: every enabled step is a boundary step.
    do_load(0, 0);
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.up = 1'($urandom_range(1));
      step("mod0", 0, 1);
    end

    // Reset mid-sequence overrides pending load.
    bus.load = 1'b1;
    bus.load_val = 4'd2;
    bus.mod_max = 4'd15;
    rst = 1'b0;
    #1;
    check("mid_rst.q", int'(bus.q), RV);
    check("mid_rst.tc", int'(bus.tc), 0);
    step("rst_held", RV, 0);
    rst = 1'b1;
    bus.load = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.en       = 1'($urandom_range(3) != 0);
      bus.up       = 1'($urandom_range(1));
      bus.load     = 1'($urandom_range(7) == 0);
      bus.load_val = W'($urandom_range(15));
      bus.sat      = 1'($urandom_range(1));
      if ($urandom_range(5) == 0) bus.mod_max = W'($urandom_range(15));
      if ($urandom_range(39) == 0) begin
        rst = 1'b0;
        #1;
        check("rnd_async_rst.q", int'(bus.q), RV);
        cycle("rnd_rst");
        rst = 1'b1;
      end else begin
        cycle("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_updown_counter.md
# sync_updown_counter

Parametrised synchronous up/down counter with enable, synchronous load, programmable modulus and wrap/saturate mode. It succeeds the fixed 4-bit down counter as the general-purpose counting primitive for timers, dividers and sequencers in the lab designs. It provides a registered terminal-count pulse for cascading.

## Interface
- WIDTH, 4, counter width in bits (≥1)
- RESET_VALUE, 0, value of q after reset (must be ≤ 2^WIDTH−1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  count enable; one step per clk while high
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value loaded when load=1
- mod_max  in  WIDTH  upper count bound; legal range is 0..mod_max
- sat  in  1  boundary mode: 0 = wrap, 1 = saturate
- q  out  WIDTH  current count, registered
- tc  out  1  terminal count, registered, one bit per boundary step

## Operation
- Priority: rst > load > en. With en=0 and load=0, q holds and tc=0.
- Load: q ← min(load_val, mod_max), tc ← 0. en is ignored that cycle.
- Up step, q < mod_max: q ← q+1, tc ← 0.
- Up step, q ≥ mod_max (boundary): wrap mode q ← 0, tc ← 1. Saturate mode q ← mod_max, tc ← 1.
- Down step, q ≠ 0 and q ≤ mod_max: q ← q−1, tc ← 0.
- Down step, q = 0 (boundary): wrap mode q ← mod_max, tc ← 1. Saturate mode q holds 0, tc ← 1.
- Down step, q > mod_max (mod_max lowered at runtime): q ← mod_max, tc ← 0. This pulls q back into range.
- mod_max = 0: every enabled step is a boundary step. q stays 0 and tc=1 each enabled cycle.
- Saturate mode at a boundary: tc stays high on every enabled cycle spent at the boundary.
- Arithmetic is modulo 2^WIDTH internally. Comparisons are unsigned. No output ever exceeds WIDTH bits.
- Inputs up, sat and mod_max may change on any cycle. The value sampled at the clock edge is the one used.

## Timing
- rst low: q = RESET_VALUE and tc = 0 immediately, independent of clk. Reset held low across any number of edges keeps these values.
- rst deassertion: the first rising edge with rst=1 performs a normal step/load evaluation. No extra wait cycle.
- Reset asserted mid-count overrides any pending load or step on that cycle.
- Latency: q and tc change exactly one clk edge after the sampled controls. There is no combinational path from any input to q or tc.
- tc is a one-cycle pulse aligned with the q value that results from the boundary step (e.g. with q=0 wrapped in, tc=1 in the same cycle).
- Cascading: a higher-order stage uses tc of the lower stage as its en. All stages share clk and rst.

## Structure
- Shared package counter_pkg holds:
  - DIR_UP = 1'b1, DIR_DOWN = 1'b0
  - MODE_WRAP = 1'b0, MODE_SAT = 1'b1
  - the default WIDTH constant
- The next-state and tc decode is combinational logic inside sync_updown_counter.
- One sub-module, dff_vec, is natural. It is a WIDTH-parametrised register with async active-low reset to a parameter value, instantiated for q and, with width 1, for tc.

## Test plan
- Reset: WIDTH=4, RESET_VALUE=5. Pulse rst low between edges -> q=5 and tc=0 at once. First edge after release with en=1, up=1, mod_max=15 -> q=6.
- Down wrap: mod_max=15, sat=0, up=0, en=1 from q=1 -> q sequence 0, 15, 14. tc=1 only in the cycle q=15.
- Up modulus: mod_max=9, sat=0, up=1 from q=8 -> q 9, 0, 1. tc=1 only with q=0. Pulse train period is 10 cycles.
- Saturate: mod_max=9, sat=1, up=1 from q=8 -> q 9, 9, 9, with tc=0, 1, 1. Then up=0 -> q 8, tc=0.
- Load priority: load=1, en=1, load_val=12, mod_max=9 -> q=9, tc=0. Then lower mod_max to 3 with up=0 -> q=3, tc=0.
- Corners: mod_max=0, en=1 for 4 cycles -> q=0 and tc=1 every cycle. Assert rst low mid-sequence -> q=RESET_VALUE with no edge needed.
